// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register stage with fixed-latency multiply commit and MTHI/MTLO
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mul_start,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               mthi,
  input  logic               mtlo,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               flush,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state, state_n;
  logic [3:0]           cnt, cnt_n;
  logic [2*WIDTH-1:0]   hold, hold_n;
  logic [WIDTH-1:0]     hi_n, lo_n;
  logic                 done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hold  <= hold_n;
      hi    <= hi_n;
      lo    <= lo_n;
      done  <= done_n;
    end
  end

  // flush overrides everything, including a same-cycle start or move
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold_n  = hold;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (mul_start) begin
            hold_n  = prod;
            cnt_n   = 4'(LATENCY - 1);
            state_n = RUN;
          end else begin
            if (mthi) hi_n = wdata;
            if (mtlo) lo_n = wdata;
          end
        end
        RUN: begin
          if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
          end else begin
            hi_n    = hold[2*WIDTH-1:WIDTH];
            lo_n    = hold[WIDTH-1:0];
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed self-checking bench for hilo_unit
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mul_start = 1'b0;
  logic [63:0] prod = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  hilo_unit #(.WIDTH(32), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .mul_start(mul_start), .prod(prod),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst = 1'b0;
    #1;
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);

    // 9*12 = 108
    tick();
    mul_start = 1'b1; prod = 64'd108;
    tick();
    mul_start = 1'b0; prod = '0;
    for (int i = 0; i < 3; i++) begin
      check("m1_busy", 64'(busy), 64'h1);
      check("m1_lo_hold", 64'(lo), 64'h0);
      check("m1_done_low", 64'(done), 64'h0);
      if (i < 2) tick();
    end
    tick();
    check("m1_hi", 64'(hi), 64'h0);
    check("m1_lo", 64'(lo), 64'd108);
    check("m1_done", 64'(done), 64'h1);
    check("m1_busy_off", 64'(busy), 64'h0);
    tick();
    check("m1_done_pulse", 64'(done), 64'h0);

    // -2*12, then back-to-back start in the done cycle
    mul_start = 1'b1; prod = 64'hFFFFFFFF_FFFFFFE8;
    tick();
    mul_start = 1'b0;
    tick(); tick(); tick();
    check("m2_hi", 64'(hi), 64'hFFFFFFFF);
    check("m2_lo", 64'(lo), 64'hFFFFFFE8);
    check("m2_done", 64'(done), 64'h1);
    mul_start = 1'b1; prod = 64'd4;
    tick();
    mul_start = 1'b0;
    check("b2b_busy", 64'(busy), 64'h1);
    check("b2b_done_low", 64'(done), 64'h0);
    tick(); tick();
    check("b2b_lo_hold", 64'(lo), 64'hFFFFFFE8);
    tick();
    check("b2b_hi", 64'(hi), 64'h0);
    check("b2b_lo", 64'(lo), 64'd4);
    check("b2b_done", 64'(done), 64'h1);

    // start held through RUN, prod changing every cycle
    tick();
    mul_start = 1'b1; prod = 64'd100;
    tick();
    prod = 64'd200; tick();
    prod = 64'd300; tick();
    prod = 64'd400; tick();
    check("held_lo", 64'(lo), 64'd100);
    check("held_done", 64'(done), 64'h1);
    prod = 64'd500;
    tick();
    mul_start = 1'b0;
    check("held_restart", 64'(busy), 64'h1);
    tick(); tick(); tick();
    check("held2_lo", 64'(lo), 64'd500);

    // flush in the second RUN cycle
    tick();
    mul_start = 1'b1; prod = 64'd108;
    tick();
    mul_start = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'h0);
    for (int i = 0; i < 3; i++) begin
      check("flush_no_done", 64'(done), 64'h0);
      tick();
    end
    check("flush_lo", 64'(lo), 64'd500);
    check("flush_hi", 64'(hi), 64'h0);
    flush = 1'b1; mul_start = 1'b1;
    tick();
    flush = 1'b0; mul_start = 1'b0;
    check("flush_start_busy", 64'(busy), 64'h0);

    // MTHI in IDLE
    mthi = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    mthi = 1'b0;
    check("mthi_hi", 64'(hi), 64'hDEADBEEF);
    check("mthi_lo", 64'(lo), 64'd500);

    // MTLO during RUN is ignored
    mul_start = 1'b1; prod = 64'd108;
    tick();
    mul_start = 1'b0;
    mtlo = 1'b1; wdata = 32'h00001234;
    tick();
    mtlo = 1'b0;
    check("mtlo_run_lo", 64'(lo), 64'd500);
    tick(); tick();
    check("mtlo_run_commit_lo", 64'(lo), 64'd108);
    check("mtlo_run_commit_hi", 64'(hi), 64'h0);

    // MTHI and MUL in the same cycle: only multiply
    mthi = 1'b1; wdata = 32'h00000055; mul_start = 1'b1; prod = {32'h7, 32'h9};
    tick();
    mthi = 1'b0; mul_start = 1'b0;
    check("mthi_mul_hi_hold", 64'(hi), 64'h0);
    tick(); tick(); tick();
    check("mthi_mul_hi", 64'(hi), 64'h7);
    check("mthi_mul_lo", 64'(lo), 64'h9);

    // asynchronous reset mid-RUN
    tick();
    mul_start = 1'b1; prod = 64'd108;
    tick();
    mul_start = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'h0);
    check("arst_lo", 64'(lo), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_done", 64'(done), 64'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("arst_no_done", 64'(done), 64'h0);
    end
    check("arst_no_commit", 64'(lo), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
